// File: rtl/counter_pkg.sv
// Shared definitions for the down-counter/timer family: state encoding and
// the illegal-state recovery rule used by the control FSM.
package counter_pkg;

   localparam int STATE_WIDTH = 2;

   localparam logic [STATE_WIDTH-1:0] ST_IDLE = 2'd0;
   localparam logic [STATE_WIDTH-1:0] ST_RUN  = 2'd1;
   localparam logic [STATE_WIDTH-1:0] ST_DONE = 2'd2;

   function automatic logic state_is_legal(input logic [STATE_WIDTH-1:0] st);
      return (st == ST_IDLE) || (st == ST_RUN) || (st == ST_DONE);
   endfunction

endpackage

// File: rtl/generic_down_counter_if.sv
// Control/status bundle of one down-counter instance. The master side
// issues commands and strobes; the slave side is the counter itself.
interface generic_down_counter_if #(
   parameter int COUNTER_WIDTH = 4
);
   logic                     STOP;
   logic                     LOAD;
   logic [COUNTER_WIDTH-1:0] LOAD_VALUE;
   logic                     START;
   logic                     ENABLE;
   logic                     AUTO_RELOAD;
   logic [COUNTER_WIDTH-1:0] COUNT;
   logic                     TRIG_OUT;
   logic                     BUSY;
   logic                     DONE;

   modport master (
      output STOP, LOAD, LOAD_VALUE, START, ENABLE, AUTO_RELOAD,
      input  COUNT, TRIG_OUT, BUSY, DONE
   );

   modport slave (
      input  STOP, LOAD, LOAD_VALUE, START, ENABLE, AUTO_RELOAD,
      output COUNT, TRIG_OUT, BUSY, DONE
   );
endinterface

// File: rtl/generic_down_counter.sv
// Loadable down counter/timer: counts from a reload value to zero on each
// ENABLE in RUN, emitting a registered one-cycle TRIG_OUT on every wrap.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | stopped; count holds, ENABLE ignored
// RUN     | count decrements on ENABLE, wraps to reload at zero
// DONE    | one-shot expired; count holds the reload value
// (2'd3)  | illegal; recovers to IDLE
module generic_down_counter
   import counter_pkg::*;
#(
   parameter int COUNTER_WIDTH = 4,
   parameter int COUNTER_MAX   = 9
) (
   input  logic                 CLK,
   input  logic                 RESET,
   generic_down_counter_if.slave bus
);

   localparam logic [COUNTER_WIDTH-1:0] CNT_RST = COUNTER_WIDTH'(COUNTER_MAX);
   localparam logic [COUNTER_WIDTH-1:0] CNT_ONE = COUNTER_WIDTH'(1);

   logic [STATE_WIDTH-1:0]   state_q, state_d;
   logic [COUNTER_WIDTH-1:0] count_q, count_d;
   logic [COUNTER_WIDTH-1:0] reload_q, reload_d;
   logic                     trig_q, trig_d;

   logic at_zero;
   logic strobe;
   logic wrap;

   assign at_zero = (count_q == '0);
   // STOP and LOAD both outrank a strobe, so neither a decrement nor a wrap
   // may happen in those cycles.
   assign strobe  = (state_q == ST_RUN) && bus.ENABLE && !bus.STOP && !bus.LOAD;
   assign wrap    = strobe && at_zero;

   always_comb begin
      state_d = state_q;
      if (!state_is_legal(state_q)) begin
         state_d = ST_IDLE;
      end else if (bus.STOP) begin
         state_d = ST_IDLE;
      end else if (bus.LOAD) begin
         state_d = state_q;
      end else begin
         case (state_q)
            ST_IDLE, ST_DONE: begin
               if (bus.START) state_d = ST_RUN;
            end
            ST_RUN: begin
               if (wrap && !bus.AUTO_RELOAD) state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      count_d  = count_q;
      reload_d = reload_q;
      if (bus.STOP) begin
         count_d  = count_q;
      end else if (bus.LOAD) begin
         count_d  = bus.LOAD_VALUE;
         reload_d = bus.LOAD_VALUE;
      end else if (strobe) begin
         count_d  = at_zero ? reload_q : (count_q - CNT_ONE);
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         count_q  <= CNT_RST;
         reload_q <= CNT_RST;
      end else begin
         count_q  <= count_d;
         reload_q <= reload_d;
      end
   end

   assign trig_d = wrap;

   always_ff @(posedge CLK) begin
      if (RESET) trig_q <= 1'b0;
      else       trig_q <= trig_d;
   end

   assign bus.COUNT    = count_q;
   assign bus.TRIG_OUT = trig_q;
   assign bus.BUSY     = (state_q == ST_RUN);
   assign bus.DONE     = (state_q == ST_DONE);

endmodule

// File: tb/tb_generic_down_counter.sv
// Scoreboard bench for generic_down_counter: directed and random stimulus
// against a behavioural model, plus a units/tens cascade.
module tb_generic_down_counter;

   logic CLK;
   logic RESET;
   logic RESET_C;

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   generic_down_counter_if #(.COUNTER_WIDTH(4)) d_if ();
   generic_down_counter_if #(.COUNTER_WIDTH(4)) u_if ();
   generic_down_counter_if #(.COUNTER_WIDTH(4)) t_if ();

   generic_down_counter #(.COUNTER_WIDTH(4), .COUNTER_MAX(9)) dut (
      .CLK(CLK), .RESET(RESET), .bus(d_if.slave)
   );

   generic_down_counter #(.COUNTER_WIDTH(4), .COUNTER_MAX(9)) units (
      .CLK(CLK), .RESET(RESET_C), .bus(u_if.slave)
   );

   generic_down_counter #(.COUNTER_WIDTH(4), .COUNTER_MAX(9)) tens (
      .CLK(CLK), .RESET(RESET_C), .bus(t_if.slave)
   );

   assign t_if.ENABLE = u_if.TRIG_OUT;

   typedef struct packed {
      logic [3:0] cnt;
      logic       trig;
      logic       busy;
      logic       done;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   typedef enum {M_IDLE, M_RUN, M_DONE} mode_t;
   mode_t m_mode;
   int    m_cnt;
   int    m_rel;
   bit    m_trig;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
      end
   endtask

   // One clock of stimulus; the model's view of the following cycle is queued
   // once the edge has passed.
   task automatic step(input bit rst, input bit stop, input bit load, input int lv,
                       input bit start, input bit en, input bit ar);
      exp_t e;
      d_if.STOP        = stop;
      d_if.LOAD        = load;
      d_if.LOAD_VALUE  = 4'(lv);
      d_if.START       = start;
      d_if.ENABLE      = en;
      d_if.AUTO_RELOAD = ar;
      RESET            = rst;
      m_trig = 1'b0;
      if (rst) begin
         m_mode = M_IDLE;
         m_cnt  = 9;
         m_rel  = 9;
      end else if (stop) begin
         m_mode = M_IDLE;
      end else if (load) begin
         m_cnt = lv % 16;
         m_rel = lv % 16;
      end else if (start && m_mode != M_RUN) begin
         m_mode = M_RUN;
      end else if (m_mode == M_RUN && en) begin
         if (m_cnt == 0) begin
            m_trig = 1'b1;
            m_cnt  = m_rel;
            if (!ar) m_mode = M_DONE;
         end else begin
            m_cnt = m_cnt - 1;
         end
      end
      e.cnt  = 4'(m_cnt);
      e.trig = m_trig;
      e.busy = (m_mode == M_RUN);
      e.done = (m_mode == M_DONE);
      @(posedge CLK);
      exp_q.push_back(e);
      #1;
   endtask

   always @(negedge CLK) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         check("count", 32'(d_if.COUNT), 32'(e.cnt));
         check("trig",  32'(d_if.TRIG_OUT), 32'(e.trig));
         check("busy",  32'(d_if.BUSY), 32'(e.busy));
         check("done",  32'(d_if.DONE), 32'(e.done));
      end
   end

   int tens_pulses = 0;
   always @(negedge CLK) begin
      if (t_if.TRIG_OUT === 1'b1) tens_pulses++;
   end

   task automatic c_tick();
      @(posedge CLK);
      #1;
   endtask

   initial begin
      d_if.STOP = 0; d_if.LOAD = 0; d_if.LOAD_VALUE = 0; d_if.START = 0;
      d_if.ENABLE = 0; d_if.AUTO_RELOAD = 0; RESET = 0;
      u_if.STOP = 0; u_if.LOAD = 0; u_if.LOAD_VALUE = 0; u_if.START = 0;
      u_if.ENABLE = 0; u_if.AUTO_RELOAD = 1;
      t_if.STOP = 0; t_if.LOAD = 0; t_if.LOAD_VALUE = 0; t_if.START = 0;
      t_if.AUTO_RELOAD = 1;
      RESET_C = 0;
      m_mode = M_IDLE; m_cnt = 9; m_rel = 9; m_trig = 0;
      #2;

      // reset, then ENABLE without START
      step(1, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, 1, 0);

      // auto-reload period
      step(0, 0, 0, 0, 1, 0, 1);
      for (int i = 0; i < 25; i++) step(0, 0, 0, 0, 0, 1, 1);
      step(0, 1, 0, 0, 0, 0, 1);

      // one-shot after LOAD 3, then re-arm from DONE
      step(0, 0, 1, 3, 0, 0, 0);
      step(0, 0, 0, 0, 1, 0, 0);
      for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 0, 1, 0);
      step(0, 0, 0, 0, 1, 0, 0);
      for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 1, 0);

      // reload 0 with gapped strobes
      step(0, 1, 0, 0, 0, 0, 1);
      step(0, 0, 1, 0, 0, 0, 1);
      step(0, 0, 0, 0, 1, 0, 1);
      for (int i = 0; i < 6; i++) begin
         step(0, 0, 0, 0, 0, 1, 1);
         step(0, 0, 0, 0, 0, 0, 1);
         step(0, 0, 0, 0, 0, 0, 1);
      end
      step(0, 0, 0, 0, 0, 1, 1);
      step(0, 0, 0, 0, 0, 1, 1);

      // collisions at count 0: LOAD wins, then STOP wins
      step(0, 1, 0, 0, 0, 0, 1);
      step(0, 0, 1, 2, 1, 0, 1);
      step(0, 0, 0, 0, 1, 0, 1);
      step(0, 0, 0, 0, 0, 1, 1);
      step(0, 0, 0, 0, 0, 1, 1);
      step(0, 0, 1, 5, 0, 1, 1);
      for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, 1, 1);
      step(0, 1, 0, 0, 0, 1, 1);
      step(0, 0, 0, 0, 0, 1, 1);

      // reset mid-count with a pending wrap
      step(0, 0, 0, 0, 1, 0, 1);
      step(1, 0, 0, 0, 0, 1, 1);
      step(0, 0, 0, 0, 0, 0, 0);

      // randomized traffic
      for (int i = 0; i < 600; i++) begin
         step(($urandom_range(0, 99) == 0),
              ($urandom_range(0, 19) == 0),
              ($urandom_range(0, 11) == 0),
              int'($urandom_range(0, 15)),
              ($urandom_range(0, 5) == 0),
              ($urandom_range(0, 3) != 0),
              ($urandom_range(0, 2) != 0));
      end

      d_if.ENABLE = 0; d_if.START = 0; d_if.LOAD = 0; d_if.STOP = 0;
      @(negedge CLK);
      #1;
      check("drain", 32'(exp_q.size()), 32'd0);

      // units/tens cascade
      RESET_C = 1;
      c_tick();
      RESET_C = 0;
      u_if.START = 1;
      t_if.START = 1;
      c_tick();
      u_if.START = 0;
      t_if.START = 0;
      check("casc_units_rst", 32'(u_if.COUNT), 32'd9);
      check("casc_tens_rst",  32'(t_if.COUNT), 32'd9);
      for (int k = 1; k <= 100; k++) begin
         u_if.ENABLE = 1;
         c_tick();
         u_if.ENABLE = 0;
         c_tick();
         c_tick();
         check("casc_units", 32'(u_if.COUNT), 32'(9 - (k % 10)));
         check("casc_tens",  32'(t_if.COUNT), 32'(9 - ((k / 10) % 10)));
      end
      check("casc_tens_pulses", 32'(tens_pulses), 32'd1);
      check("casc_tens_busy",   32'(t_if.BUSY), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout actual=running required=finished");
      $fatal(1);
   end

endmodule
